clk_strobe_hub: RTL and testbench

Single-clock enable-strobe generator that derives the decade rate ticks (10 MHz … 1 Hz) and a selectable sampling strobe from the 50 MHz fundamental clock. It runs beside the divided-clock hub and feeds logic in the 50 MHz domain, so that logic steps at slow rates without extra clock domains. It also drives the environment's sampling strobe and keeps an elapsed-seconds count.

---
 rtl/clk_strobe_hub_if.sv | 41 ++++
 rtl/clk_strobe_hub.sv | 125 ++++++++++++
 tb/tb_clk_strobe_hub.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_strobe_hub_if.sv
// ---------------------------------------------------------------------------
// clk_strobe_hub_if
// Bundles the control inputs and strobe outputs of clk_strobe_hub.
//   run          : count enable (low freezes all dividers)
//   clear        : synchronous realign of dividers and sec_cnt
//   sel[3:0]     : sampling-rate select (0=10MHz .. 8=1Hz, 9..15 off)
//   stb_*        : single-cycle decade rate strobes
//   sampling_stb : registered copy of the selected strobe
//   sec_cnt      : number of 1 Hz strobes seen, wraps modulo 2^SEC_W
// master = the environment driving run/clear/sel; slave = the strobe hub.
// ---------------------------------------------------------------------------
interface clk_strobe_hub_if #(
  parameter int SEC_W = 16
);
  logic             run;
  logic             clear;
  logic [3:0]       sel;
  logic             stb_10MHz;
  logic             stb_5MHz;
  logic             stb_1MHz;
  logic             stb_100kHz;
  logic             stb_10kHz;
  logic             stb_1kHz;
  logic             stb_100Hz;
  logic             stb_10Hz;
  logic             stb_1Hz;
  logic             sampling_stb;
  logic [SEC_W-1:0] sec_cnt;

  modport master (
    output run, clear, sel,
    input  stb_10MHz, stb_5MHz, stb_1MHz, stb_100kHz, stb_10kHz,
           stb_1kHz, stb_100Hz, stb_10Hz, stb_1Hz, sampling_stb, sec_cnt
  );

  modport slave (
    input  run, clear, sel,
    output stb_10MHz, stb_5MHz, stb_1MHz, stb_100kHz, stb_10kHz,
           stb_1kHz, stb_100Hz, stb_10Hz, stb_1Hz, sampling_stb, sec_cnt
  );
endinterface

// File: rtl/clk_strobe_hub.sv
// ---------------------------------------------------------------------------
// clk_strobe_hub
// Enable-strobe generator for the 50 MHz domain: produces decade rate
// strobes (10 MHz .. 1 Hz), a 5 MHz strobe, a selectable sampling strobe
// and an elapsed-seconds counter, all without additional clock domains.
// Ports:
//   clk : 50 MHz fundamental clock
//   rst : synchronous active-high reset (clears everything incl. sel_q)
//   hub : clk_strobe_hub_if.slave (run/clear/sel in, strobes/sec_cnt out)
// Strobe vector bit order matches the sel encoding:
//   [0]=10MHz [1]=5MHz [2]=1MHz [3]=100kHz [4]=10kHz [5]=1kHz
//   [6]=100Hz [7]=10Hz [8]=1Hz
// ---------------------------------------------------------------------------
module clk_strobe_hub #(
  parameter int PRESCALE = 5,
  parameter int DECADE   = 10,
  parameter int SEC_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  clk_strobe_hub_if.slave  hub
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = (DECADE > 1) ? $clog2(DECADE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DECADE - 1);

  logic [PW-1:0]         r_p;
  logic                  r_h;
  logic [7:1][DW-1:0]    r_d;
  logic [3:0]            r_sel_q;
  logic [SEC_W-1:0]      r_sec;
  logic [8:0]            r_stb_p1;
  logic                  r_samp_p2;

  logic                  w_en;
  logic [8:0]            w_tick_p0;

  function automatic logic sel_strobe(input logic [3:0] s, input logic [8:0] stb);
    logic o;
    case (s)
      4'd0:    o = stb[0];
      4'd1:    o = stb[1];
      4'd2:    o = stb[2];
      4'd3:    o = stb[3];
      4'd4:    o = stb[4];
      4'd5:    o = stb[5];
      4'd6:    o = stb[6];
      4'd7:    o = stb[7];
      4'd8:    o = stb[8];
      default: o = 1'b0;
    endcase
    return o;
  endfunction

  // ---- p0: tick decode from current divider state ----
  always_comb begin
    w_tick_p0    = '0;
    // clear outranks run, so a tick on a clearing edge is dropped
    w_en         = hub.run & ~hub.clear;
    w_tick_p0[0] = w_en && (r_p == P_LAST);
    w_tick_p0[1] = w_tick_p0[0] && r_h;
    w_tick_p0[2] = w_tick_p0[0] && (r_d[1] == D_LAST);
    for (int k = 2; k <= 7; k++) begin
      w_tick_p0[k+1] = w_tick_p0[k] && (r_d[k] == D_LAST);
    end
  end

  // ---- p1: divider state, registered strobes, seconds count ----
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p       <= '0;
      r_h       <= 1'b0;
      r_d       <= '0;
      r_sel_q   <= '0;
      r_sec     <= '0;
      r_stb_p1  <= '0;
      r_samp_p2 <= 1'b0;
    end else begin
      // sel_q tracks sel on every non-reset edge, frozen or clearing alike
      r_sel_q   <= hub.sel;
      r_samp_p2 <= sel_strobe(r_sel_q, r_stb_p1);
      if (hub.clear) begin
        r_p      <= '0;
        r_h      <= 1'b0;
        r_d      <= '0;
        r_sec    <= '0;
        r_stb_p1 <= '0;
      end else begin
        r_stb_p1 <= w_tick_p0;
        if (hub.run) begin
          r_p <= (r_p == P_LAST) ? '0 : r_p + PW'(1);
        end
        if (w_tick_p0[0]) begin
          r_h    <= ~r_h;
          r_d[1] <= (r_d[1] == D_LAST) ? '0 : r_d[1] + DW'(1);
        end
        // level k counter steps on the tick of level k-1 (tick index k)
        for (int k = 2; k <= 7; k++) begin
          if (w_tick_p0[k]) begin
            r_d[k] <= (r_d[k] == D_LAST) ? '0 : r_d[k] + DW'(1);
          end
        end
        if (w_tick_p0[8]) begin
          r_sec <= r_sec + SEC_W'(1);
        end
      end
    end
  end

  // ---- p2: outputs ----
  assign hub.stb_10MHz    = r_stb_p1[0];
  assign hub.stb_5MHz     = r_stb_p1[1];
  assign hub.stb_1MHz     = r_stb_p1[2];
  assign hub.stb_100kHz   = r_stb_p1[3];
  assign hub.stb_10kHz    = r_stb_p1[4];
  assign hub.stb_1kHz     = r_stb_p1[5];
  assign hub.stb_100Hz    = r_stb_p1[6];
  assign hub.stb_10Hz     = r_stb_p1[7];
  assign hub.stb_1Hz      = r_stb_p1[8];
  assign hub.sampling_stb = r_samp_p2;
  assign hub.sec_cnt      = r_sec;

endmodule

// File: tb/tb_clk_strobe_hub.sv
// ---------------------------------------------------------------------------
// tb_clk_strobe_hub
// Directed bench for clk_strobe_hub with PRESCALE=5, DECADE=2, SEC_W=2.
// A table of {edge, strobes, sampling_stb, sec_cnt} checkpoints covers the
// free-running chain; hand-written sequences cover reset mid-count, run
// freeze, sel changes, clear with sec_cnt, and clear on a tick edge.
// ---------------------------------------------------------------------------
module tb_clk_strobe_hub;

  localparam int PRESCALE = 5;
  localparam int DECADE   = 2;
  localparam int SEC_W    = 2;

  logic clk;
  logic rst;

  clk_strobe_hub_if #(.SEC_W(SEC_W)) hub ();

  clk_strobe_hub #(
    .PRESCALE(PRESCALE),
    .DECADE  (DECADE),
    .SEC_W   (SEC_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hub(hub)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    int               edge_n;
    logic [8:0]       stb;
    logic             samp;
    logic [SEC_W-1:0] sec;
  } vec_t;

  vec_t vecs [21];
  int   n_vec;
  int   n_bad;

  function automatic logic [8:0] stbs();
    return {hub.stb_1Hz, hub.stb_10Hz, hub.stb_100Hz, hub.stb_1kHz,
            hub.stb_10kHz, hub.stb_100kHz, hub.stb_1MHz, hub.stb_5MHz,
            hub.stb_10MHz};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string name);
    check({name, ".stb"},  32'(stbs()), 32'h0);
    check({name, ".samp"}, 32'(hub.sampling_stb), 32'h0);
    check({name, ".sec"},  32'(hub.sec_cnt), 32'h0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    hub.run   = 1'b1;
    hub.clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_zero("reset");
    end
    rst = 1'b0;
  endtask

  initial begin
    int cur;
    n_vec     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    hub.run   = 1'b0;
    hub.clear = 1'b0;
    hub.sel   = 4'd2;

    // level k (0=10MHz, k>=1 decade) strobes after multiples of 5*2^k
    vecs[0]  = '{1,    9'h000, 1'b0, 2'd0};
    vecs[1]  = '{4,    9'h000, 1'b0, 2'd0};
    vecs[2]  = '{5,    9'h001, 1'b0, 2'd0};
    vecs[3]  = '{10,   9'h007, 1'b0, 2'd0};
    vecs[4]  = '{11,   9'h000, 1'b1, 2'd0};
    vecs[5]  = '{15,   9'h001, 1'b0, 2'd0};
    vecs[6]  = '{20,   9'h00F, 1'b0, 2'd0};
    vecs[7]  = '{21,   9'h000, 1'b1, 2'd0};
    vecs[8]  = '{25,   9'h001, 1'b0, 2'd0};
    vecs[9]  = '{30,   9'h007, 1'b0, 2'd0};
    vecs[10] = '{40,   9'h01F, 1'b0, 2'd0};
    vecs[11] = '{80,   9'h03F, 1'b0, 2'd0};
    vecs[12] = '{160,  9'h07F, 1'b0, 2'd0};
    vecs[13] = '{320,  9'h0FF, 1'b0, 2'd0};
    vecs[14] = '{639,  9'h000, 1'b0, 2'd0};
    vecs[15] = '{640,  9'h1FF, 1'b0, 2'd1};
    vecs[16] = '{641,  9'h000, 1'b1, 2'd1};
    vecs[17] = '{1280, 9'h1FF, 1'b0, 2'd2};
    vecs[18] = '{1920, 9'h1FF, 1'b0, 2'd3};
    vecs[19] = '{1921, 9'h000, 1'b1, 2'd3};
    vecs[20] = '{2560, 9'h1FF, 1'b0, 2'd0};

    // free-running chain with sel=2 (1 MHz)
    do_reset();
    cur = 0;
    for (int v = 0; v < 21; v++) begin
      while (cur < vecs[v].edge_n) begin
        tick();
        cur++;
      end
      check($sformatf("tab%0d.stb", vecs[v].edge_n),  32'(stbs()), 32'(vecs[v].stb));
      check($sformatf("tab%0d.samp", vecs[v].edge_n), 32'(hub.sampling_stb), 32'(vecs[v].samp));
      check($sformatf("tab%0d.sec", vecs[v].edge_n),  32'(hub.sec_cnt), 32'(vecs[v].sec));
    end

    // reset mid-count at edge 7: phase restarts from zero
    do_reset();
    repeat (7) tick();
    rst = 1'b1;
    tick();
    check_zero("midrst1");
    tick();
    check_zero("midrst2");
    rst = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("midrst_e%0d", i), 32'(stbs()), 32'h0);
    end
    tick();
    check("midrst_e5", 32'(stbs()), 32'h001);

    // run low for 3 cycles after edge 3: tick slips to clock 8
    do_reset();
    repeat (3) tick();
    hub.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("frz%0d", i), 32'(stbs()), 32'h0);
    end
    hub.run = 1'b1;
    tick();
    check("frz_clk7", 32'(stbs()), 32'h0);
    tick();
    check("frz_clk8", 32'(stbs()), 32'h001);

    // sel 2 -> 12 forces sampling_stb low; then sel 0 follows 10 MHz
    hub.sel = 4'd2;
    do_reset();
    repeat (10) tick();
    check("sel_1m_e10", 32'(hub.stb_1MHz), 32'h1);
    hub.sel = 4'd12;
    tick();
    check("sel_e11", 32'(hub.sampling_stb), 32'h1);
    tick();
    check("sel_off_e12", 32'(hub.sampling_stb), 32'h0);
    hub.sel = 4'd0;
    repeat (3) tick();
    check("sel0_e15", 32'(hub.sampling_stb), 32'h0);
    tick();
    check("sel0_e16", 32'(hub.sampling_stb), 32'h1);

    // clear during count zeroes sec_cnt and restarts phase, sel kept
    do_reset();
    repeat (643) tick();
    check("clr_sec_before", 32'(hub.sec_cnt), 32'h1);
    hub.clear = 1'b1;
    tick();
    check("clr_stb", 32'(stbs()), 32'h0);
    check("clr_sec", 32'(hub.sec_cnt), 32'h0);
    hub.clear = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("clr_e%0d", i), 32'(stbs()), 32'h0);
    end
    tick();
    check("clr_e5_stb", 32'(stbs()), 32'h001);
    check("clr_e5_sec", 32'(hub.sec_cnt), 32'h0);
    tick();
    check("clr_e6_samp", 32'(hub.sampling_stb), 32'h1);

    // clear on the edge that would produce a 10 MHz tick
    do_reset();
    repeat (4) tick();
    hub.clear = 1'b1;
    tick();
    check("clrtick_drop", 32'(stbs()), 32'h0);
    hub.clear = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("clrtick_e%0d", i), 32'(stbs()), 32'h0);
    end
    tick();
    check("clrtick_e5", 32'(stbs()), 32'h001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
